// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one four_bitalu between two valid/ready requesters.
// One operation is in flight at a time; results return on the owner's response port.

module four_bitalu (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] sel_i,
  output logic [3:0] result_o,
  output logic       carry_o
);

  logic [4:0] sum;

  // ADD/SUB use a 5-bit datapath so bit 4 is the carry (SUB: borrow); every other op clears it.
  always_comb begin
    sum = 5'd0;
    case (sel_i)
      3'b000: sum = {1'b0, a_i} + {1'b0, b_i};
      3'b001: sum = {1'b0, a_i} - {1'b0, b_i};
      3'b010: sum = {1'b0, a_i & b_i};
      3'b011: sum = {1'b0, a_i | b_i};
      3'b100: sum = {1'b0, a_i ^ b_i};
      3'b101: sum = {1'b0, ~a_i};
      3'b110: sum = {1'b0, a_i[2:0], 1'b0};
      3'b111: sum = {2'b00, a_i[3:1]};
    endcase
  end

  assign result_o = sum[3:0];
  assign carry_o  = sum[4];

endmodule

module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       valid_q, valid_d;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       grant0, grant1, rsp_hs;

  four_bitalu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .sel_i    (sel_q),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  assign grant0     = req0_valid && (!req1_valid || !prio_q);
  assign grant1     = req1_valid && (!req0_valid ||  prio_q);
  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;
  assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;

  // The counter starts at EXEC_CYCLES so the first EXEC cycle lets the freshly captured
  // operands settle on the ALU; the result is sampled EXEC_CYCLES cycles after that.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d     = req0_a;
          b_d     = req0_b;
          sel_d   = req0_sel;
          owner_d = 1'b0;
          cnt_d   = 4'(EXEC_CYCLES);
          state_d = EXEC;
        end else if (req1_ready) begin
          a_d     = req1_a;
          b_d     = req1_b;
          sel_d   = req1_sel;
          owner_d = 1'b1;
          cnt_d   = 4'(EXEC_CYCLES);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_result;
          carry_d  = alu_carry;
          valid_d  = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          valid_d = 1'b0;
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      sel_q    <= 3'd0;
      cnt_q    <= 4'd0;
      result_q <= 4'd0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
    end
  end

  assign rsp0_valid = valid_q && !owner_q;
  assign rsp1_valid = valid_q &&  owner_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a fixed vector table, randomized operations against an
// arithmetic reference model, and hand-written reset/back-pressure sequences.

module tb_alu_arbiter;

  localparam int EXEC_A = 1;
  localparam int EXEC_B = 4;

  logic       clk;
  logic       rstN[2];
  logic       req0Valid[2], req1Valid[2], req0Ready[2], req1Ready[2];
  logic [3:0] req0A[2], req0B[2], req1A[2], req1B[2];
  logic [2:0] req0Sel[2], req1Sel[2];
  logic       rsp0Valid[2], rsp1Valid[2], rsp0Ready[2], rsp1Ready[2];
  logic [3:0] rspResult[2];
  logic       rspCarry[2];
  logic       busy[2];

  int checks = 0;
  int failures = 0;
  int refPrio[2];

  alu_arbiter #(.EXEC_CYCLES(EXEC_A)) dutFast (
    .clk(clk), .rst_n(rstN[0]),
    .req0_valid(req0Valid[0]), .req0_ready(req0Ready[0]),
    .req0_a(req0A[0]), .req0_b(req0B[0]), .req0_sel(req0Sel[0]),
    .req1_valid(req1Valid[0]), .req1_ready(req1Ready[0]),
    .req1_a(req1A[0]), .req1_b(req1B[0]), .req1_sel(req1Sel[0]),
    .rsp0_valid(rsp0Valid[0]), .rsp0_ready(rsp0Ready[0]),
    .rsp1_valid(rsp1Valid[0]), .rsp1_ready(rsp1Ready[0]),
    .rsp_result(rspResult[0]), .rsp_carry(rspCarry[0]), .busy(busy[0])
  );

  alu_arbiter #(.EXEC_CYCLES(EXEC_B)) dutSlow (
    .clk(clk), .rst_n(rstN[1]),
    .req0_valid(req0Valid[1]), .req0_ready(req0Ready[1]),
    .req0_a(req0A[1]), .req0_b(req0B[1]), .req0_sel(req0Sel[1]),
    .req1_valid(req1Valid[1]), .req1_ready(req1Ready[1]),
    .req1_a(req1A[1]), .req1_b(req1B[1]), .req1_sel(req1Sel[1]),
    .rsp0_valid(rsp0Valid[1]), .rsp0_ready(rsp0Ready[1]),
    .rsp1_valid(rsp1Valid[1]), .rsp1_ready(rsp1Ready[1]),
    .rsp_result(rspResult[1]), .rsp_carry(rspCarry[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mask;
    logic [3:0] a0, b0;
    logic [2:0] s0;
    logic [3:0] a1, b1;
    logic [2:0] s1;
    int         owner;
    logic [3:0] res;
    logic       carry;
    int         rspDelay;
    int         holdOther;
  } vec_t;

  // Reference ALU built from plain integer arithmetic on the opcode meanings.
  function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    int x, y, r;
    bit c;
    x = int'(a);
    y = int'(b);
    c = 1'b0;
    r = 0;
    case (sel)
      3'd0: begin r = x + y; c = (r > 15); end
      3'd1: begin r = x - y; c = (r < 0); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = 15 - x;
      3'd6: r = x * 2;
      3'd7: r = x / 2;
    endcase
    r = ((r % 16) + 16) % 16;
    return {c, 4'(r)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic scramble(input int d);
    req0A[d] = 4'($urandom); req0B[d] = 4'($urandom); req0Sel[d] = 3'($urandom);
    req1A[d] = 4'($urandom); req1B[d] = 4'($urandom); req1Sel[d] = 3'($urandom);
  endtask

  task automatic setOtherValid(input int d, input int owner, input logic v);
    if (owner == 0) req1Valid[d] = v;
    else            req0Valid[d] = v;
  endtask

  // One full transaction: present requests, check the grant, latency, response data,
  // hold behaviour under back-pressure and the response handshake.
  task automatic applyStimulus(input int d, input vec_t v, input string name);
    int waitCnt, lat, expLat;
    logic [3:0] heldRes;
    logic heldCarry, ownValid, othReady, othRspValid;
    expLat = (d == 0) ? EXEC_A + 1 : EXEC_B + 1;
    @(negedge clk);
    req0Valid[d] = v.mask[0]; req0A[d] = v.a0; req0B[d] = v.b0; req0Sel[d] = v.s0;
    req1Valid[d] = v.mask[1]; req1A[d] = v.a1; req1B[d] = v.b1; req1Sel[d] = v.s1;
    #1;
    waitCnt = 0;
    while (!(req0Ready[d] || req1Ready[d]) && waitCnt < 20) begin
      @(negedge clk); #1; waitCnt++;
    end
    checkOutput({name, " grant wait"}, waitCnt, 0);
    if (waitCnt >= 20) begin
      req0Valid[d] = 1'b0; req1Valid[d] = 1'b0;
      return;
    end
    checkOutput({name, " grant"}, {req1Ready[d], req0Ready[d]}, (v.owner == 1) ? 2'b10 : 2'b01);
    @(posedge clk);
    @(negedge clk);
    req0Valid[d] = 1'b0; req1Valid[d] = 1'b0;
    scramble(d);
    #1;
    checkOutput({name, " busy exec"}, busy[d], 1);
    lat = 0;
    while (!(rsp0Valid[d] || rsp1Valid[d]) && lat < 40) begin
      @(negedge clk); scramble(d); #1; lat++;
    end
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " rsp port"}, {rsp1Valid[d], rsp0Valid[d]}, (v.owner == 1) ? 2'b10 : 2'b01);
    checkOutput({name, " result"}, rspResult[d], v.res);
    checkOutput({name, " carry"}, rspCarry[d], v.carry);
    heldRes = rspResult[d];
    heldCarry = rspCarry[d];
    if (v.holdOther != 0) setOtherValid(d, v.owner, 1'b1);
    for (int i = 0; i < v.rspDelay; i++) begin
      @(negedge clk);
      if (v.owner == 0) rsp1Ready[d] = 1'($urandom);
      else              rsp0Ready[d] = 1'($urandom);
      #1;
      ownValid = (v.owner == 0) ? rsp0Valid[d] : rsp1Valid[d];
      othReady = (v.owner == 0) ? req1Ready[d] : req0Ready[d];
      checkOutput({name, " hold valid"}, ownValid, 1);
      checkOutput({name, " hold result"}, {rspCarry[d], rspResult[d]}, {heldCarry, heldRes});
      checkOutput({name, " hold req ready"}, othReady, 0);
      checkOutput({name, " hold busy"}, busy[d], 1);
    end
    @(negedge clk);
    rsp0Ready[d] = (v.owner == 0);
    rsp1Ready[d] = (v.owner == 1);
    @(posedge clk);
    @(negedge clk);
    rsp0Ready[d] = 1'b0; rsp1Ready[d] = 1'b0;
    #1;
    othRspValid = rsp0Valid[d] | rsp1Valid[d];
    checkOutput({name, " rsp cleared"}, othRspValid, 0);
    if (v.holdOther != 0) begin
      othReady = (v.owner == 0) ? req1Ready[d] : req0Ready[d];
      checkOutput({name, " waiting req granted"}, othReady, 1);
      setOtherValid(d, v.owner, 1'b0);
    end
    refPrio[d] = (v.owner == 0) ? 1 : 0;
  endtask

  task automatic runRandom(input int d, input int count);
    vec_t v;
    logic [4:0] r;
    for (int i = 0; i < count; i++) begin
      v.mask = 2'($urandom_range(1, 3));
      v.a0 = 4'($urandom); v.b0 = 4'($urandom); v.s0 = 3'($urandom);
      v.a1 = 4'($urandom); v.b1 = 4'($urandom); v.s1 = 3'($urandom);
      v.owner = (v.mask == 2'b11) ? refPrio[d] : ((v.mask == 2'b10) ? 1 : 0);
      r = (v.owner == 0) ? aluRef(v.a0, v.b0, v.s0) : aluRef(v.a1, v.b1, v.s1);
      v.res = r[3:0];
      v.carry = r[4];
      v.rspDelay = $urandom_range(0, 3);
      v.holdOther = $urandom_range(0, 1);
      applyStimulus(d, v, $sformatf("rand%0d_%0d", d, i));
    end
  endtask

  vec_t table_[$];
  logic seen;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0;
      req0Valid[d] = 1'b1; req1Valid[d] = 1'b1;
      req0A[d] = 4'd0; req0B[d] = 4'd0; req0Sel[d] = 3'd0;
      req1A[d] = 4'd0; req1B[d] = 4'd0; req1Sel[d] = 3'd0;
      rsp0Ready[d] = 1'b0; rsp1Ready[d] = 1'b0;
      refPrio[d] = 0;
    end

    // Reset state, with requests present to show ready is held low.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset ready", {req0Ready[0], req1Ready[0]}, 2'b00);
    checkOutput("reset rsp valid", {rsp0Valid[0], rsp1Valid[0]}, 2'b00);
    checkOutput("reset result", {rspCarry[0], rspResult[0]}, 5'd0);
    checkOutput("reset busy", busy[0], 0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req0Valid[d] = 1'b0; req1Valid[d] = 1'b0; rstN[d] = 1'b1;
    end

    //        mask   a0     b0     s0    a1     b1     s1    own res    c  dly hold
    table_.push_back('{2'b01, 4'h5, 4'h3, 3'd0, 4'h0, 4'h0, 3'd0, 0, 4'h8, 0, 0, 0});
    table_.push_back('{2'b10, 4'h0, 4'h0, 3'd0, 4'hF, 4'h1, 3'd0, 1, 4'h0, 1, 0, 0});
    table_.push_back('{2'b10, 4'h0, 4'h0, 3'd0, 4'h5, 4'h0, 3'd5, 1, 4'hA, 0, 0, 0});
    table_.push_back('{2'b10, 4'h0, 4'h0, 3'd0, 4'h5, 4'h0, 3'd6, 1, 4'hA, 0, 0, 0});
    table_.push_back('{2'b10, 4'h0, 4'h0, 3'd0, 4'h5, 4'h0, 3'd7, 1, 4'h2, 0, 0, 0});
    table_.push_back('{2'b11, 4'h5, 4'h3, 3'd2, 4'h5, 4'h3, 3'd3, 0, 4'h1, 0, 0, 0});
    table_.push_back('{2'b11, 4'h5, 4'h3, 3'd2, 4'h5, 4'h3, 3'd3, 1, 4'h7, 0, 0, 0});
    table_.push_back('{2'b11, 4'h5, 4'h3, 3'd2, 4'h5, 4'h3, 3'd3, 0, 4'h1, 0, 0, 0});
    table_.push_back('{2'b11, 4'h5, 4'h3, 3'd2, 4'h5, 4'h3, 3'd3, 1, 4'h7, 0, 0, 0});
    table_.push_back('{2'b01, 4'h3, 4'h5, 3'd1, 4'h0, 4'h0, 3'd0, 0, 4'hE, 1, 0, 0});
    table_.push_back('{2'b01, 4'hC, 4'hA, 3'd4, 4'h0, 4'h0, 3'd0, 0, 4'h6, 0, 5, 1});
    table_.push_back('{2'b10, 4'h0, 4'h0, 3'd0, 4'h9, 4'h8, 3'd0, 1, 4'h1, 1, 2, 0});
    foreach (table_[i]) applyStimulus(0, table_[i], $sformatf("vec%0d", i));

    // Long execute window: operand changes during EXEC are ignored by the capture.
    applyStimulus(1, '{2'b01, 4'h5, 4'h3, 3'd4, 4'h0, 4'h0, 3'd0, 0, 4'h6, 0, 0, 0}, "exec4 xor");

    runRandom(0, 40);
    runRandom(1, 15);

    // Reset in the middle of EXEC drops the operation entirely.
    @(negedge clk);
    req0Valid[0] = 1'b1; req0A[0] = 4'h7; req0B[0] = 4'h1; req0Sel[0] = 3'd0;
    #1;
    checkOutput("midrst accept ready", req0Ready[0], 1);
    @(posedge clk);
    @(negedge clk);
    rstN[0] = 1'b0;
    #1;
    checkOutput("midrst ready", {req0Ready[0], req1Ready[0]}, 2'b00);
    checkOutput("midrst rsp", {rsp0Valid[0], rsp1Valid[0]}, 2'b00);
    checkOutput("midrst result", {rspCarry[0], rspResult[0]}, 5'd0);
    checkOutput("midrst busy", busy[0], 0);
    @(negedge clk);
    req0Valid[0] = 1'b0;
    rstN[0] = 1'b1;
    refPrio[0] = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      seen = seen | rsp0Valid[0] | rsp1Valid[0] | busy[0];
    end
    checkOutput("midrst no response", seen, 0);
    applyStimulus(0, '{2'b11, 4'h2, 4'h3, 3'd0, 4'hF, 4'hF, 3'd0, 0, 4'h5, 0, 1, 0}, "post reset prio0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
